// File: rtl/click_pkg.sv
// Shared types and constants for the click decoder.
package click_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  localparam int MAX_CLICKS = 3;
  localparam int CLICK_W    = 2;
  localparam int DROP_W     = 8;

  // Click count increment that sticks at MAX_CLICKS.
  function automatic logic [CLICK_W-1:0] clicks_sat_inc(input logic [CLICK_W-1:0] c);
    if (c >= CLICK_W'(MAX_CLICKS)) begin
      return c;
    end
    return c + CLICK_W'(1);
  endfunction

endpackage

// File: rtl/click_decoder_window_timer.sv
// Inter-click window timer: counts up from 0 and flags the last window cycle.
module window_timer #(
  parameter int WINDOW_CYC = 50000000,
  parameter int CNT_W      = $clog2(WINDOW_CYC)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired_o = (cnt_q == CNT_W'(WINDOW_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/click_decoder.sv
// Groups press pulses into single/double/triple click events behind a valid/ready register.
// Optional dropped-event counter on drop_cnt when CLICK_DECODER_DROP_CNT_EN is defined.
module click_decoder
  import click_pkg::*;
#(
  parameter int WINDOW_CYC = 50000000,
  parameter int CNT_W      = $clog2(WINDOW_CYC)
) (
  input  logic               fpga_clk,
  input  logic               rst,
  input  logic               button_edge,
  input  logic               evt_ready,
  output logic               evt_valid,
  output logic [CLICK_W-1:0] evt_count
`ifdef CLICK_DECODER_DROP_CNT_EN
  ,
  output logic [DROP_W-1:0]  drop_cnt
`endif
);

  state_e             state_q, state_d;
  logic               edge_q;
  logic [CLICK_W-1:0] clicks_q, clicks_d;
  logic               evt_valid_q, evt_valid_d;
  logic [CLICK_W-1:0] evt_count_q, evt_count_d;
  logic               tmr_clear;
  logic               tmr_en;
  logic               tmr_expired;
  logic               load_req;
  logic               load_ok;

  // The press pulse is registered first so the FSM acts one cycle after sampling.
  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      edge_q <= 1'b0;
    end else begin
      edge_q <= button_edge;
    end
  end

  window_timer #(
    .WINDOW_CYC (WINDOW_CYC),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk_i     (fpga_clk),
    .rst_i     (rst),
    .clear_i   (tmr_clear),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    clicks_d  = clicks_q;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    load_req  = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_clear = 1'b1;
        if (edge_q) begin
          state_d  = COLLECT;
          clicks_d = CLICK_W'(1);
        end
      end
      COLLECT: begin
        // A new press beats a simultaneous expiry and reopens the window.
        if (edge_q) begin
          clicks_d  = clicks_sat_inc(clicks_q);
          tmr_clear = 1'b1;
        end else if (tmr_expired) begin
          load_req  = 1'b1;
          state_d   = IDLE;
          clicks_d  = '0;
          tmr_clear = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        clicks_d = '0;
      end
    endcase
  end

  assign load_ok = load_req && (!evt_valid_q || evt_ready);

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_count_d = evt_count_q;
    if (load_ok) begin
      evt_valid_d = 1'b1;
      evt_count_d = clicks_q;
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      clicks_q    <= '0;
      evt_valid_q <= 1'b0;
      evt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      clicks_q    <= clicks_d;
      evt_valid_q <= evt_valid_d;
      evt_count_q <= evt_count_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_count = evt_count_q;

`ifdef CLICK_DECODER_DROP_CNT_EN
  logic [DROP_W-1:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (load_req && !load_ok && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_click_decoder.sv
// Self-checking bench for click_decoder with WINDOW_CYC = 8.
// Drop-counter checks are active when CLICK_DECODER_DROP_CNT_EN is defined.
module tb_click_decoder;

  logic       fpga_clk;
  logic       rst;
  logic       button_edge;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_count;
`ifdef CLICK_DECODER_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  click_decoder #(
    .WINDOW_CYC (8),
    .CNT_W      (3)
  ) dut (
    .fpga_clk    (fpga_clk),
    .rst         (rst),
    .button_edge (button_edge),
    .evt_ready   (evt_ready),
    .evt_valid   (evt_valid),
    .evt_count   (evt_count)
`ifdef CLICK_DECODER_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  initial fpga_clk = 1'b0;
  always #5 fpga_clk = ~fpga_clk;

  typedef struct {
    string       name;
    logic [39:0] mask;
    int          ev1;
    logic [1:0]  cnt1;
    int          ev2;
    logic [1:0]  cnt2;
  } vec_t;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", name, k, act, exp);
    end
  endtask

  // Drive the inputs sampled at the next rising edge, then move 1 ns past it.
  task automatic step(input logic be, input logic rdy, input logic r);
    button_edge = be;
    evt_ready   = rdy;
    rst         = r;
    @(posedge fpga_clk);
    #1;
  endtask

  // Presses during reset must be ignored.
  task automatic do_reset();
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
  endtask

  task automatic chk_drop(input string name, input int k, input int exp);
`ifdef CLICK_DECODER_DROP_CNT_EN
    chk(name, k, 32'(drop_cnt), 32'(exp));
`endif
  endtask

  vec_t vt[8];

  initial begin
    logic exp_v;

    vt[0] = '{"single",     40'h1,                              9,  2'd1, -1, 2'd0};
    vt[1] = '{"double",     (40'h1 | (40'h1 << 5)),             14, 2'd2, -1, 2'd0};
    vt[2] = '{"boundary",   (40'h1 | (40'h1 << 8)),             17, 2'd2, -1, 2'd0};
    vt[3] = '{"late",       (40'h1 | (40'h1 << 7)),             16, 2'd2, -1, 2'd0};
    vt[4] = '{"backtoback", 40'h3,                              10, 2'd2, -1, 2'd0};
    vt[5] = '{"triple",     (40'h1 | (40'h1 << 3) | (40'h1 << 6)), 15, 2'd3, -1, 2'd0};
    vt[6] = '{"saturate",   40'h155,                            17, 2'd3, -1, 2'd0};
    vt[7] = '{"split",      (40'h1 | (40'h1 << 9)),             9,  2'd1, 18, 2'd1};

    button_edge = 1'b0;
    evt_ready   = 1'b1;
    rst         = 1'b1;

    do_reset();
    chk("rst_valid", -1, 32'(evt_valid), 32'd0);
    chk("rst_count", -1, 32'(evt_count), 32'd0);
    chk_drop("rst_drop", -1, 0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      for (int k = 0; k < 40; k++) begin
        step(vt[i].mask[k], 1'b1, 1'b0);
        exp_v = (k == vt[i].ev1) || (k == vt[i].ev2);
        chk({vt[i].name, "_valid"}, k, 32'(evt_valid), 32'(exp_v));
        if (exp_v) begin
          chk({vt[i].name, "_count"}, k, 32'(evt_count),
              32'((k == vt[i].ev1) ? vt[i].cnt1 : vt[i].cnt2));
        end
      end
    end

    // Back-pressure: first event held, second (double) discarded.
    do_reset();
    for (int k = 0; k < 36; k++) begin
      step((k == 0) || (k == 17) || (k == 20), (k >= 31), 1'b0);
      exp_v = (k >= 9) && (k <= 30);
      chk("bp_valid", k, 32'(evt_valid), 32'(exp_v));
      if (exp_v) chk("bp_count", k, 32'(evt_count), 32'd1);
      chk_drop("bp_drop", k, (k >= 29) ? 1 : 0);
    end
    step(1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    chk("bp_rst_valid", 36, 32'(evt_valid), 32'd0);
    chk_drop("bp_rst_drop", 36, 0);

    // Accept-and-reload in the expiry cycle of the second event.
    do_reset();
    for (int k = 0; k < 33; k++) begin
      step((k == 0) || (k == 17) || (k == 20), (k >= 29), 1'b0);
      exp_v = (k >= 9) && (k <= 29);
      chk("ar_valid", k, 32'(evt_valid), 32'(exp_v));
      if (exp_v) chk("ar_count", k, 32'(evt_count), (k <= 28) ? 32'd1 : 32'd2);
      chk_drop("ar_drop", k, 0);
    end

    // Reset during a pending, unaccepted event.
    do_reset();
    for (int k = 0; k < 26; k++) begin
      step(k == 0, 1'b0, k == 12);
      exp_v = (k >= 9) && (k <= 11);
      chk("mh_valid", k, 32'(evt_valid), 32'(exp_v));
      if (k == 12) chk("mh_count", k, 32'(evt_count), 32'd0);
    end

    // Reset mid-window, then a fresh click.
    do_reset();
    for (int k = 0; k < 26; k++) begin
      step((k == 0) || (k == 10), 1'b1, k == 5);
      exp_v = (k == 19);
      chk("mw_valid", k, 32'(evt_valid), 32'(exp_v));
      if (exp_v) chk("mw_count", k, 32'(evt_count), 32'd1);
      if (k == 5) begin
        chk("mw_rst_count", k, 32'(evt_count), 32'd0);
        chk_drop("mw_rst_drop", k, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
